instr_fetch_unit: RTL

// - Instruction fetch front end of the MIPS32 core. Fetches one 32-bit word per PC from instruction memory over a

---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues one word fetch per PC over a
// valid/ready request + valid response memory port, holds the returned
// word for decode under a valid/ready handshake, and accepts taken
// branch/jump redirects from execute. One memory request in flight at most.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [31:0] id_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  // Keeps the request low while reset is held and rises one edge after release.
  logic        req_en_q;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        req_fire;

  assign pc_plus4       = pc_q + 32'd4;
  assign redirect_pc    = redirect_target & ~32'h3;
  assign imem_req_valid = req_en_q && (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_opcode   = id_instr_q[31:26];
  assign id_pc_plus4 = id_pc4_q;

  // Next-state logic; a redirect outranks every other event in the same cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    squash_d   = squash_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (req_fire) begin
          state_d  = ST_WAIT;
          // Request already left with the old PC; its response must be discarded.
          squash_d = redirect_valid;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rsp_valid) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            id_instr_d = imem_rsp_data;
            id_pc4_d   = pc_plus4;
            pc_d       = pc_plus4;
            id_valid_d = 1'b1;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          id_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (id_ready) begin
          id_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      squash_q   <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc4_q   <= '0;
      req_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      squash_q   <= squash_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      req_en_q   <= 1'b1;
    end
  end

endmodule
